// File: rtl/aes_pkg.sv
// Shared AES constants, MixColumns FSM state encoding and GF(2^8) helpers.
// Polynomial 0x11b. Used by mix_cols_seq and mix_col_word.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul4(input logic [7:0] b);
        return xtime(xtime(b));
    endfunction

endpackage

// File: rtl/mix_col_word.sv
// Combinational MixColumns transform of one 32-bit column (row 0 in [31:24]).
// The InvMixColumns pre-transform is only built with AES_INV_MIX_EN defined.
module mix_col_word
    import aes_pkg::*;
(
    input  logic                 inv,
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] a0, a1, a2, a3, t;

`ifdef AES_INV_MIX_EN
    logic [7:0] u, v;

    // Inverse = forward transform applied after folding 4*(a0^a2) / 4*(a1^a3) in.
    always_comb begin
        u  = mul4(col_in[31:24] ^ col_in[15:8]);
        v  = mul4(col_in[23:16] ^ col_in[7:0]);
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];
        if (inv) begin
            a0 = col_in[31:24] ^ u;
            a1 = col_in[23:16] ^ v;
            a2 = col_in[15:8]  ^ u;
            a3 = col_in[7:0]   ^ v;
        end
    end
`else
    logic unused_inv;
    assign unused_inv       = inv;
    assign {a0, a1, a2, a3} = col_in;
`endif

    assign t       = a0 ^ a1 ^ a2 ^ a3;
    assign col_out = {a0 ^ t ^ xtime(a0 ^ a1),
                      a1 ^ t ^ xtime(a1 ^ a2),
                      a2 ^ t ^ xtime(a2 ^ a3),
                      a3 ^ t ^ xtime(a3 ^ a0)};

endmodule

// File: rtl/mix_cols_seq.sv
// Handshaked AES MixColumns unit, COLS_PER_CYC columns per clock, with final-round bypass.
// Optional InvMixColumns support is enabled by defining AES_INV_MIX_EN.
module mix_cols_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] state_in,
    input  logic                   bypass,
    input  logic                   inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   busy
);

    localparam int         N        = 4 / COLS_PER_CYC;
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYC);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYC);

    if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4)) begin : g_bad_cols
        $error("mix_cols_seq: COLS_PER_CYC must be 1, 2 or 4 (N=%0d)", N);
    end

    fsm_state_e             state_q, state_d;
    logic [1:0]             col_cnt_q, col_cnt_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [AES_STATE_W-1:0] state_out_q, state_out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   bypass_q, bypass_d;
    logic                   inv_q, inv_d;
    logic                   inv_sel;
    logic                   accept;

`ifdef AES_INV_MIX_EN
    assign inv_sel = inv;
`else
    logic unused_inv_in;
    assign unused_inv_in = inv;
    assign inv_sel       = 1'b0;
`endif

    logic [1:0]           sel      [COLS_PER_CYC];
    logic [AES_COL_W-1:0] word_in  [COLS_PER_CYC];
    logic [AES_COL_W-1:0] word_out [COLS_PER_CYC];

    // Multiplier g works on column col_cnt+g of the captured state.
    for (genvar g = 0; g < COLS_PER_CYC; g++) begin : g_col
        assign sel[g]     = col_cnt_q + 2'(g);
        assign word_in[g] = work_q[{sel[g], 5'b0} +: AES_COL_W];

        mix_col_word u_word (
            .inv     (inv_q),
            .col_in  (word_in[g]),
            .col_out (word_out[g])
        );
    end

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign state_out = state_out_q;
    assign busy      = (state_q == RUN) || (state_q == DONE);

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        work_d      = work_q;
        state_out_d = state_out_q;
        out_valid_d = out_valid_q;
        bypass_d    = bypass_q;
        inv_d       = inv_q;

        case (state_q)
            IDLE: ;
            RUN: begin
                if (!bypass_q) begin
                    for (int g = 0; g < COLS_PER_CYC; g++) begin
                        state_out_d[{sel[g], 5'b0} +: AES_COL_W] = word_out[g];
                    end
                    col_cnt_d = col_cnt_q + CNT_STEP;
                    if (col_cnt_q == CNT_LAST) begin
                        col_cnt_d   = 2'd0;
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new accept overrides the DONE->IDLE retirement in the same cycle.
        if (accept) begin
            work_d    = state_in;
            bypass_d  = bypass;
            inv_d     = inv_sel;
            col_cnt_d = 2'd0;
            if (bypass) begin
                state_d     = DONE;
                state_out_d = state_in;
                out_valid_d = 1'b1;
            end else begin
                state_d     = RUN;
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_cnt_q   <= 2'd0;
            work_q      <= '0;
            state_out_q <= '0;
            out_valid_q <= 1'b0;
            bypass_q    <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            work_q      <= work_d;
            state_out_q <= state_out_d;
            out_valid_q <= out_valid_d;
            bypass_q    <= bypass_d;
            inv_q       <= inv_d;
        end
    end

endmodule

// File: doc/mix_cols_seq.md
Name: mix_cols_seq

Overview:
- Parametrised, handshaked AES MixColumns unit.
- Processes a 128-bit state over 4/COLS_PER_CYC cycles, with COLS_PER_CYC column multipliers working in parallel.
- Supports a final-round bypass and, optionally, InvMixColumns for decryption.
- Sits between ShiftRows and AddRoundKey in the iterative round datapath.

Parameters:
- COLS_PER_CYC, 1, columns processed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- N (derived localparam), 4/COLS_PER_CYC, number of RUN cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  state_in/bypass/inv are valid.
- in_ready  out  1  unit can accept a state this cycle.
- state_in  in  128  input state; column j = bits [32j+31:32j]; within a column, bits [31:24] = row 0.
- bypass  in  1  final round: pass state through unchanged.
- inv  in  1  1 = InvMixColumns. Ignored without INV_MIX_EN.
- out_valid  out  1  state_out holds a result.
- out_ready  in  1  downstream accepts the result.
- state_out  out  128  result, registered.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: all of the following are cleared at a clk edge with rst_n=0, regardless of state:
  - FSM goes to IDLE.
  - out_valid=0, state_out=0, col_cnt=0.
  - Captured bypass/inv flags are cleared.
  - in_ready=1 from the first cycle after reset releases.
- Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- Accept condition: in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Back-to-back issue is therefore legal.
- On accept:
  - state_in is captured into the working register; bypass and inv are latched.
  - bypass=0 -> RUN, col_cnt=0.
  - bypass=1 -> DONE directly; state_out = state_in; out_valid=1 after 1 clock.
- RUN: each clock, columns col_cnt .. col_cnt+COLS_PER_CYC-1 are transformed and written into state_out. Other columns are not modified.
  - col_cnt increments by COLS_PER_CYC.
  - When the last group is written, col_cnt wraps to 0, state -> DONE and out_valid=1.
  - out_valid therefore rises N clocks after the accepting edge.
- DONE: state_out and out_valid are held stable while out_ready=0.
  - out_ready=1 and no new accept -> IDLE, out_valid=0.
  - out_ready=1 and accept in the same cycle -> RUN (or DONE if bypass). out_valid drops for the RUN period.
- out_ready while out_valid=0: no effect. in_valid while in_ready=0: ignored; the input is not captured.
- Column arithmetic, GF(2^8), polynomial 0x11b:
  - Forward: t = a0^a1^a2^a3; ai' = ai ^ t ^ xtime(ai ^ a(i+1 mod 4)).
  - Inverse: precompute u = xtime(xtime(a0^a2)) and v = xtime(xtime(a1^a3)); apply a0^=u, a1^=v, a2^=u, a3^=v; then run the forward transform.
- state_out bits not yet written in the current RUN keep their previous value. They must not be sampled before out_valid=1.

Optional Feature:
- Macro: AES_INV_MIX_EN.
- Defined: inv selects InvMixColumns per operation. The latched inv selects the pre-transform in every column multiplier.
- Undefined: the pre-transform logic is not built. inv is ignored and treated as 0. The port remains in the interface.

Decomposition:
- Shared package aes_pkg holds:
  - AES_STATE_W=128, AES_COL_W=32.
  - FSM state enum (IDLE/RUN/DONE).
  - Functions xtime and mul4.
- One sub-module, mix_col_word: 32-bit combinational forward/inverse column transform with an inv input. It is instantiated COLS_PER_CYC times, and column selection is muxed by col_cnt.

Test Plan:
- COLS_PER_CYC=1, forward:
  - state_in = 128'h2d26314c_d4d4d4d5_c6c6c6c6_f20a225c.
  - Expect state_out = 128'h4d7ebdf8_d5d5d7d6_c6c6c6c6_9fdc589d, with out_valid exactly 4 clocks after accept.
- COLS_PER_CYC=4, same vector:
  - Identical result with 1-clock latency.
- COLS_PER_CYC=2, AES_INV_MIX_EN, inv=1:
  - state_in = 128'h4d7ebdf8_d5d5d7d6_c6c6c6c6_9fdc589d.
  - Expect 128'h2d26314c_d4d4d4d5_c6c6c6c6_f20a225c after 2 clocks.
- bypass=1, state_in = 128'h88372bfc53cd15a7b0467618f934d52b:
  - Expect an identical state_out with out_valid after 1 clock.
- Backpressure:
  - Hold out_ready=0 for 5 clocks in DONE. state_out must be stable and in_ready=0.
  - Then assert out_ready with in_valid=1 (new state 128'hdb135345...). Accept must happen in the same cycle; a column 32'hdb135345 yields 32'h8e4da1bc.
- Reset mid-RUN:
  - Drive rst_n=0 at the 2nd RUN clock.
  - Next cycle: out_valid=0, state_out=0, in_ready=1. A subsequent operation completes correctly.
